// File: rtl/integ_pkg.sv
// Shared types and constants for the multichannel integrator: FSM states,
// integration-rule encodings and saturation limits for an N-bit signed word.
package integ_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic MODE_RECT = 1'b0;
   localparam logic MODE_TRAP = 1'b1;

   localparam int MAX_W = 128;

   // Limits are returned wide; callers truncate to their own N.
   function automatic logic [MAX_W-1:0] SAT_MAX(input int n);
      return {MAX_W{1'b1}} >> (MAX_W - n + 1);
   endfunction

   function automatic logic [MAX_W-1:0] SAT_MIN(input int n);
      return MAX_W'(1) << (n - 1);
   endfunction

endpackage

// File: rtl/multichannel_integrator_if.sv
// Sample/result bus between the velocity producers, the integrator and the
// altitude calculator.
interface multichannel_integrator_if #(
   parameter int N  = 64,
   parameter int CH = 4
);
   logic            sample_valid;
   logic            sample_ready;
   logic [CH*N-1:0] sample_data;
   logic            mode;
   logic [CH-1:0]   clear_mask;
   logic [CH-1:0]   hold_mask;
   logic [CH*N-1:0] result;
   logic            result_valid;
   logic [CH-1:0]   overflow;

   modport master (
      output sample_valid, sample_data, mode, clear_mask, hold_mask,
      input  sample_ready, result, result_valid, overflow
   );

   modport slave (
      input  sample_valid, sample_data, mode, clear_mask, hold_mask,
      output sample_ready, result, result_valid, overflow
   );
endinterface

// File: rtl/integ_sat_add.sv
// Combinational integration step for one channel: forms the rectangular or
// trapezoidal increment and adds it to the accumulator with saturation.
module integ_sat_add
   import integ_pkg::*;
#(
   parameter int N        = 64,
   parameter int DT_SHIFT = 0
) (
   input  logic signed [N-1:0] acc_i,
   input  logic signed [N-1:0] x_i,
   input  logic signed [N-1:0] p_i,
   input  logic                mode_i,
   input  logic                first_i,
   output logic signed [N-1:0] acc_o,
   output logic                sat_o
);
   localparam logic signed [N-1:0] MAX_V = N'(SAT_MAX(N));
   localparam logic signed [N-1:0] MIN_V = N'(SAT_MIN(N));

   logic signed [N-1:0] p_eff;
   logic signed [N:0]   x_ext;
   logic signed [N:0]   p_ext;
   logic signed [N:0]   pair_sum;
   logic signed [N-1:0] inc;
   logic signed [N:0]   total;

   always_comb begin
      p_eff    = first_i ? x_i : p_i;
      x_ext    = {x_i[N-1], x_i};
      p_ext    = {p_eff[N-1], p_eff};
      pair_sum = x_ext + p_ext;
      // The halved pair sum always fits back into N bits.
      if (mode_i == MODE_TRAP) inc = N'(pair_sum >>> (DT_SHIFT + 1));
      else                     inc = x_i >>> DT_SHIFT;
      total = {acc_i[N-1], acc_i} + {inc[N-1], inc};
      sat_o = total[N] ^ total[N-1];
      if (!sat_o)        acc_o = total[N-1:0];
      else if (total[N]) acc_o = MIN_V;
      else               acc_o = MAX_V;
   end
endmodule

// File: rtl/multichannel_integrator.sv
// CH-channel fixed-point integrator sharing one saturating adder; channels are
// stepped one per cycle after each accepted sample vector.
//
//  state    | meaning
//  ---------+-----------------------------------------------------
//  ST_IDLE  | ready for a sample vector; sample_ready high
//  ST_ACCUM | stepping channel idx_q through the shared adder
//  ST_DONE  | all channels updated; result_valid high this cycle
module multichannel_integrator
   import integ_pkg::*;
#(
   parameter int N        = 64,
   parameter int CH       = 4,
   parameter int DT_SHIFT = 0
) (
   input logic                        clk,
   input logic                        resetb,
   multichannel_integrator_if.slave   bus
);
   localparam int IW = (CH > 1) ? $clog2(CH) : 1;

   state_e              state_q;
   logic [IW-1:0]       idx_q;
   logic [CH*N-1:0]     samp_q;
   logic                mode_q;
   logic [CH-1:0]       clr_q;
   logic [CH-1:0]       hold_q;
   logic signed [N-1:0] acc_q  [CH];
   logic signed [N-1:0] prev_q [CH];
   logic [CH-1:0]       first_q;
   logic [CH-1:0]       ovf_q;
   logic                ready_q;
   logic                rv_q;

   logic signed [N-1:0] x_cur;
   logic signed [N-1:0] acc_d;
   logic                sat_d;

   assign x_cur = samp_q[idx_q*N +: N];

   integ_sat_add #(.N(N), .DT_SHIFT(DT_SHIFT)) u_core (
      .acc_i   (acc_q[idx_q]),
      .x_i     (x_cur),
      .p_i     (prev_q[idx_q]),
      .mode_i  (mode_q),
      .first_i (first_q[idx_q]),
      .acc_o   (acc_d),
      .sat_o   (sat_d)
   );

   always_ff @(posedge clk) begin
      if (resetb) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         samp_q  <= '0;
         mode_q  <= MODE_RECT;
         clr_q   <= '0;
         hold_q  <= '0;
         first_q <= '1;
         ovf_q   <= '0;
         ready_q <= 1'b1;
         rv_q    <= 1'b0;
         for (int k = 0; k < CH; k++) begin
            acc_q[k]  <= '0;
            prev_q[k] <= '0;
         end
      end else begin
         rv_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.sample_valid && ready_q) begin
                  samp_q  <= bus.sample_data;
                  mode_q  <= bus.mode;
                  clr_q   <= bus.clear_mask;
                  hold_q  <= bus.hold_mask;
                  idx_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               // Clear outranks hold; hold keeps tracking prev but not first.
               if (clr_q[idx_q]) begin
                  acc_q[idx_q]   <= '0;
                  ovf_q[idx_q]   <= 1'b0;
                  prev_q[idx_q]  <= x_cur;
                  first_q[idx_q] <= 1'b0;
               end else if (hold_q[idx_q]) begin
                  prev_q[idx_q]  <= x_cur;
               end else begin
                  acc_q[idx_q]   <= acc_d;
                  if (sat_d) ovf_q[idx_q] <= 1'b1;
                  prev_q[idx_q]  <= x_cur;
                  first_q[idx_q] <= 1'b0;
               end
               if (idx_q == IW'(CH - 1)) begin
                  state_q <= ST_DONE;
                  rv_q    <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.sample_ready = ready_q;
   assign bus.result_valid = rv_q;
   assign bus.overflow     = ovf_q;

   for (genvar g = 0; g < CH; g++) begin : g_result
      assign bus.result[g*N +: N] = acc_q[g];
   end
endmodule

// File: tb/tb_multichannel_integrator.sv
// Directed bench: two integrators (DT_SHIFT 0 and 1, N=16, CH=4) driven in
// lockstep from one stimulus bus, each scenario checked against hand values.
module tb_multichannel_integrator;
   import integ_pkg::*;

   localparam int N  = 16;
   localparam int CH = 4;

   logic clk = 1'b0;
   logic resetb;
   always #5 clk = ~clk;

   multichannel_integrator_if #(.N(N), .CH(CH)) ia ();
   multichannel_integrator_if #(.N(N), .CH(CH)) ib ();

   assign ib.sample_valid = ia.sample_valid;
   assign ib.sample_data  = ia.sample_data;
   assign ib.mode         = ia.mode;
   assign ib.clear_mask   = ia.clear_mask;
   assign ib.hold_mask    = ia.hold_mask;

   multichannel_integrator #(.N(N), .CH(CH), .DT_SHIFT(0)) dut_a (
      .clk(clk), .resetb(resetb), .bus(ia.slave));
   multichannel_integrator #(.N(N), .CH(CH), .DT_SHIFT(1)) dut_b (
      .clk(clk), .resetb(resetb), .bus(ib.slave));

   int checks   = 0;
   int failures = 0;

   function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      resetb = 1'b1;
      repeat (2) @(negedge clk);
      resetb = 1'b0;
   endtask

   // lat = posedges from the accept edge to the first edge after which
   // result_valid is seen high; -1 if it never arrives.
   task automatic send(input logic [63:0] d, input logic m, input logic [3:0] clr,
                       input logic [3:0] hold, output int lat);
      int w;
      @(negedge clk);
      ia.sample_valid = 1'b1;
      ia.sample_data  = d;
      ia.mode         = m;
      ia.clear_mask   = clr;
      ia.hold_mask    = hold;
      w = 0;
      while (!ia.sample_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1 ia.sample_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (ia.result_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      resetb = 1'b1;
      ia.sample_valid = 1'b1;
      ia.sample_data  = pack4(5, 5, 5, 5);
      repeat (3) @(negedge clk);
      checks++;
      if (ia.result !== 64'd0 || ia.overflow !== 4'b0) begin
         failures++;
         $display("FAIL reset_values result=%h ovf=%b required 0/0000", ia.result, ia.overflow);
      end
      checks++;
      if (ia.sample_ready !== 1'b1 || ia.result_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_handshake ready=%b rv=%b required 1/0", ia.sample_ready, ia.result_valid);
      end
      resetb = 1'b0;
      ia.sample_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (ia.sample_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_wins_over_valid ready=%b required 1", ia.sample_ready);
      end
   endtask

   task automatic test_rect();
      int lat;
      do_reset();
      for (int s = 1; s <= 3; s++) begin
         send(pack4(1000, 2000, -500, 0), MODE_RECT, 4'b0, 4'b0, lat);
         checks++;
         if (lat != CH) begin
            failures++;
            $display("FAIL rect_latency_s%0d got=%0d required=%0d", s, lat, CH);
         end
         checks++;
         if (ia.result !== pack4(1000*s, 2000*s, -500*s, 0)) begin
            failures++;
            $display("FAIL rect_result_s%0d got=%h required=%h", s, ia.result,
                     pack4(1000*s, 2000*s, -500*s, 0));
         end
         @(posedge clk);
         #1;
         checks++;
         if (ia.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL rect_pulse_width_s%0d rv=%b required 0", s, ia.result_valid);
         end
      end
      checks++;
      if (ib.result !== pack4(1500, 3000, -750, 0)) begin
         failures++;
         $display("FAIL rect_dt1_result got=%h required=%h", ib.result, pack4(1500, 3000, -750, 0));
      end
   endtask

   task automatic test_trap();
      int lat;
      logic [63:0] xin [3];
      logic [63:0] ea [3];
      logic [63:0] eb [3];
      xin[0] = pack4(0, 3, -100, 0);   ea[0] = pack4(0, 3, -100, 0);   eb[0] = pack4(0, 1, -50, 0);
      xin[1] = pack4(100, 3, -100, 0); ea[1] = pack4(50, 6, -200, 0);  eb[1] = pack4(25, 2, -100, 0);
      xin[2] = pack4(200, 3, -100, 0); ea[2] = pack4(200, 9, -300, 0); eb[2] = pack4(100, 3, -150, 0);
      do_reset();
      for (int s = 0; s < 3; s++) begin
         send(xin[s], MODE_TRAP, 4'b0, 4'b0, lat);
         checks++;
         if (ia.result !== ea[s]) begin
            failures++;
            $display("FAIL trap_dt0_s%0d got=%h required=%h", s, ia.result, ea[s]);
         end
         checks++;
         if (ib.result !== eb[s]) begin
            failures++;
            $display("FAIL trap_dt1_s%0d got=%h required=%h", s, ib.result, eb[s]);
         end
      end
      send(pack4(1, 1, 1, 1), MODE_RECT, 4'b0, 4'b0, lat);
      checks++;
      if (ia.result !== pack4(201, 10, -299, 1)) begin
         failures++;
         $display("FAIL mode_switch_rect got=%h required=%h", ia.result, pack4(201, 10, -299, 1));
      end
      send(pack4(3, 3, 3, 3), MODE_TRAP, 4'b0, 4'b0, lat);
      checks++;
      if (ia.result !== pack4(203, 12, -297, 3)) begin
         failures++;
         $display("FAIL mode_switch_trap got=%h required=%h", ia.result, pack4(203, 12, -297, 3));
      end
   endtask

   task automatic test_sat();
      int lat;
      int bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         send(pack4(0, 1000, -1000, 0), MODE_RECT, 4'b0, 4'b0, lat);
         if (lat != CH) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL sat_ramp_latency bad_samples=%0d required=0", bad);
      end
      send(pack4(0, 760, -760, 0), MODE_RECT, 4'b0, 4'b0, lat);
      checks++;
      if (ia.result !== pack4(0, 32760, -32760, 0) || ia.overflow !== 4'b0000) begin
         failures++;
         $display("FAIL sat_near got=%h ovf=%b required=%h/0000", ia.result, ia.overflow,
                  pack4(0, 32760, -32760, 0));
      end
      send(pack4(0, 100, -100, 0), MODE_RECT, 4'b0, 4'b0, lat);
      checks++;
      if (ia.result !== pack4(0, 32767, -32768, 0) || ia.overflow !== 4'b0110) begin
         failures++;
         $display("FAIL sat_clamp got=%h ovf=%b required=%h/0110", ia.result, ia.overflow,
                  pack4(0, 32767, -32768, 0));
      end
      send(pack4(0, -10, 10, 0), MODE_RECT, 4'b0, 4'b0, lat);
      checks++;
      if (ia.result !== pack4(0, 32757, -32758, 0) || ia.overflow !== 4'b0110) begin
         failures++;
         $display("FAIL sat_sticky got=%h ovf=%b required=%h/0110", ia.result, ia.overflow,
                  pack4(0, 32757, -32758, 0));
      end
      send(pack4(0, 0, 0, 0), MODE_RECT, 4'b0010, 4'b0, lat);
      checks++;
      if (ia.result !== pack4(0, 0, -32758, 0) || ia.overflow !== 4'b0100) begin
         failures++;
         $display("FAIL sat_clear got=%h ovf=%b required=%h/0100", ia.result, ia.overflow,
                  pack4(0, 0, -32758, 0));
      end
   endtask

   task automatic test_clear_hold();
      int lat;
      do_reset();
      send(pack4(10, 20, 30, 40), MODE_RECT, 4'b0, 4'b0, lat);
      send(pack4(5, 5, 5, 5), MODE_RECT, 4'b0001, 4'b0011, lat);
      checks++;
      if (ia.result !== pack4(0, 20, 35, 45)) begin
         failures++;
         $display("FAIL clear_over_hold got=%h required=%h", ia.result, pack4(0, 20, 35, 45));
      end
      send(pack4(7, 7, 7, 7), MODE_TRAP, 4'b0, 4'b0, lat);
      checks++;
      if (ia.result !== pack4(6, 26, 41, 51)) begin
         failures++;
         $display("FAIL hold_tracks_prev got=%h required=%h", ia.result, pack4(6, 26, 41, 51));
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] d [3];
      int nacc, npulse, last;
      int intv [2];
      logic rdy;
      d[0] = pack4(1, 0, 0, -1);
      d[1] = pack4(2, 0, 0, -2);
      d[2] = pack4(4, 0, 0, -4);
      nacc = 0; npulse = 0; last = -1; intv[0] = 0; intv[1] = 0;
      do_reset();
      ia.mode = MODE_RECT;
      ia.clear_mask = 4'b0;
      ia.hold_mask = 4'b0;
      ia.sample_valid = 1'b1;
      ia.sample_data = d[0];
      for (int c = 0; c < 30; c++) begin
         rdy = ia.sample_ready;
         if (ia.result_valid) npulse++;
         @(posedge clk);
         if (rdy && ia.sample_valid) begin
            if (nacc > 0 && nacc < 3) intv[nacc-1] = c - last;
            last = c;
            nacc++;
            #1;
            if (nacc < 3) ia.sample_data = d[nacc];
            else          ia.sample_valid = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (nacc != 3) begin
         failures++;
         $display("FAIL b2b_accepts got=%0d required=3", nacc);
      end
      checks++;
      if (intv[0] != CH + 2 || intv[1] != CH + 2) begin
         failures++;
         $display("FAIL b2b_interval got=%0d,%0d required=%0d", intv[0], intv[1], CH + 2);
      end
      checks++;
      if (npulse != 3) begin
         failures++;
         $display("FAIL b2b_pulses got=%0d required=3", npulse);
      end
      checks++;
      if (ia.result !== pack4(7, 0, 0, -7)) begin
         failures++;
         $display("FAIL b2b_result got=%h required=%h", ia.result, pack4(7, 0, 0, -7));
      end
   endtask

   task automatic test_reset_mid();
      int lat, npulse;
      do_reset();
      @(negedge clk);
      ia.sample_valid = 1'b1;
      ia.sample_data  = pack4(300, 0, 0, 0);
      ia.mode         = MODE_TRAP;
      ia.clear_mask   = 4'b0;
      ia.hold_mask    = 4'b0;
      @(posedge clk);
      #1 ia.sample_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetb = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ia.result !== 64'd0 || ia.overflow !== 4'b0 || ia.result_valid !== 1'b0 ||
          ia.sample_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_outputs result=%h ovf=%b rv=%b ready=%b required 0/0000/0/1",
                  ia.result, ia.overflow, ia.result_valid, ia.sample_ready);
      end
      @(negedge clk);
      resetb = 1'b0;
      npulse = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ia.result_valid) npulse++;
      end
      checks++;
      if (npulse != 0) begin
         failures++;
         $display("FAIL mid_reset_no_pulse got=%0d required=0", npulse);
      end
      send(pack4(100, 0, 0, 0), MODE_TRAP, 4'b0, 4'b0, lat);
      checks++;
      if (lat != CH || ia.result !== pack4(100, 0, 0, 0)) begin
         failures++;
         $display("FAIL mid_reset_first_sample lat=%0d got=%h required=%0d/%h", lat, ia.result,
                  CH, pack4(100, 0, 0, 0));
      end
   endtask

   initial begin
      ia.sample_valid = 1'b0;
      ia.sample_data  = '0;
      ia.mode         = MODE_RECT;
      ia.clear_mask   = '0;
      ia.hold_mask    = '0;
      test_reset();
      test_rect();
      test_trap();
      test_sat();
      test_clear_hold();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
